// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: sample mode encoding and the elaboration-time
// arctangent table generator used by every CORDIC block in wave_former.
package cordic_pkg;

  typedef enum logic {
    CORDIC_ROTATE = 1'b0,
    CORDIC_VECTOR = 1'b1
  } cordic_mode_t;

  localparam real CORDIC_PI = 3.14159265358979323846;

  // atan(2^-i) expressed in angle units where 2^(z_width-1) is pi,
  // rounded to nearest. Only ever evaluated for constant arguments.
  function automatic int cordic_atan(input int i, input int z_width);
    real t;
    real full_scale;
    real scaled;
    t = 1.0;
    for (int k = 0; k < i; k++) begin
      t = t / 2.0;
    end
    full_scale = 1.0;
    for (int k = 0; k < z_width - 1; k++) begin
      full_scale = full_scale * 2.0;
    end
    scaled = $atan(t) / CORDIC_PI * full_scale;
    return $rtoi(scaled + 0.5);
  endfunction

endpackage

// File: rtl/cordic_pipe_stage.sv
// One registered CORDIC micro-rotation. The direction is taken from the
// sign of z (rotate) or y (vector) of the incoming sample, and both x and y
// updates use the stage-input values so the stage is a single clean adder level.
module cordic_pipe_stage
  import cordic_pkg::*;
#(
  parameter int XY_W      = 18,
  parameter int Z_WIDTH   = 16,
  parameter int TAG_WIDTH = 8,
  parameter int IDX       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        src_valid,
  input  cordic_mode_t                src_mode,
  input  logic                        src_zero,
  input  logic signed [XY_W-1:0]      src_x,
  input  logic signed [XY_W-1:0]      src_y,
  input  logic signed [Z_WIDTH-1:0]   src_z,
  input  logic        [TAG_WIDTH-1:0] src_tag,
  output logic                        dst_valid,
  output cordic_mode_t                dst_mode,
  output logic                        dst_zero,
  output logic signed [XY_W-1:0]      dst_x,
  output logic signed [XY_W-1:0]      dst_y,
  output logic signed [Z_WIDTH-1:0]   dst_z,
  output logic        [TAG_WIDTH-1:0] dst_tag
);

  localparam logic signed [Z_WIDTH-1:0] ATAN = Z_WIDTH'(cordic_atan(IDX, Z_WIDTH));

  logic signed [XY_W-1:0]    x_sh;
  logic signed [XY_W-1:0]    y_sh;
  logic signed [XY_W-1:0]    x_nx;
  logic signed [XY_W-1:0]    y_nx;
  logic signed [Z_WIDTH-1:0] z_nx;
  logic                      dir;

  // Pick the rotation direction and form the next x/y/z for this sample.
  always_comb begin
    x_sh = src_x >>> IDX;
    y_sh = src_y >>> IDX;
    dir  = (src_mode == CORDIC_ROTATE) ? src_z[Z_WIDTH-1] : ~src_y[XY_W-1];
    if (dir) begin
      x_nx = src_x + y_sh;
      y_nx = src_y - x_sh;
      z_nx = src_z + ATAN;
    end else begin
      x_nx = src_x - y_sh;
      y_nx = src_y + x_sh;
      z_nx = src_z - ATAN;
    end
  end

  // Stage register: cleared by reset, otherwise advances with the global enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_valid <= 1'b0;
      dst_mode  <= CORDIC_ROTATE;
      dst_zero  <= 1'b0;
      dst_x     <= '0;
      dst_y     <= '0;
      dst_z     <= '0;
      dst_tag   <= '0;
    end else if (ce) begin
      dst_valid <= src_valid;
      dst_mode  <= src_mode;
      dst_zero  <= src_zero;
      dst_x     <= x_nx;
      dst_y     <= y_nx;
      dst_z     <= z_nx;
      dst_tag   <= src_tag;
    end
  end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC engine, one sample per clock. A quadrant
// pre-rotation register folds the input into the convergence range, then
// STAGES micro-rotation registers follow. The whole pipe shares one enable so
// backpressure from the output freezes every stage together.
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int XY_WIDTH  = 16,
  parameter int Z_WIDTH   = 16,
  parameter int STAGES    = 16,
  parameter int TAG_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          s_mode,
  input  logic signed [XY_WIDTH-1:0]    s_x,
  input  logic signed [XY_WIDTH-1:0]    s_y,
  input  logic signed [Z_WIDTH-1:0]     s_z,
  input  logic        [TAG_WIDTH-1:0]   s_tag,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [XY_WIDTH+1:0]    m_x,
  output logic signed [XY_WIDTH+1:0]    m_y,
  output logic signed [Z_WIDTH-1:0]     m_z,
  output logic                          m_mode,
  output logic        [TAG_WIDTH-1:0]   m_tag
);

  localparam int XY_W = XY_WIDTH + 2;

  logic                      ce;
  cordic_mode_t              s_mode_e;

  logic signed [XY_W-1:0]    xe;
  logic signed [XY_W-1:0]    ye;
  logic signed [XY_W-1:0]    pre_x;
  logic signed [XY_W-1:0]    pre_y;
  logic signed [Z_WIDTH-1:0] pre_z;
  logic                      pre_zero;

  logic                      pre_valid_q;
  cordic_mode_t              pre_mode_q;
  logic                      pre_zero_q;
  logic signed [XY_W-1:0]    pre_x_q;
  logic signed [XY_W-1:0]    pre_y_q;
  logic signed [Z_WIDTH-1:0] pre_z_q;
  logic [TAG_WIDTH-1:0]      pre_tag_q;

  logic                      pipe_valid [0:STAGES];
  cordic_mode_t              pipe_mode  [0:STAGES];
  logic                      pipe_zero  [0:STAGES];
  logic signed [XY_W-1:0]    pipe_x     [0:STAGES];
  logic signed [XY_W-1:0]    pipe_y     [0:STAGES];
  logic signed [Z_WIDTH-1:0] pipe_z     [0:STAGES];
  logic [TAG_WIDTH-1:0]      pipe_tag   [0:STAGES];

  // The pipe moves whenever the output register is empty or being drained.
  assign ce       = !m_valid || m_ready;
  assign s_ready  = ce;
  assign s_mode_e = cordic_mode_t'(s_mode);

  // Quadrant pre-rotation: bring the problem into +/-pi/2 where the
  // micro-rotations converge, and flag the degenerate zero vector.
  always_comb begin
    xe       = {{2{s_x[XY_WIDTH-1]}}, s_x};
    ye       = {{2{s_y[XY_WIDTH-1]}}, s_y};
    pre_x    = xe;
    pre_y    = ye;
    pre_z    = s_z;
    pre_zero = 1'b0;
    if (s_mode_e == CORDIC_ROTATE) begin
      if (s_z[Z_WIDTH-1] ^ s_z[Z_WIDTH-2]) begin
        pre_x = -xe;
        pre_y = -ye;
        pre_z = {~s_z[Z_WIDTH-1], s_z[Z_WIDTH-2:0]};
      end
    end else begin
      pre_z = '0;
      if (xe[XY_W-1]) begin
        pre_x = -xe;
        pre_y = -ye;
        pre_z = {1'b1, {(Z_WIDTH-1){1'b0}}};
      end
      pre_zero = (s_x == '0) && (s_y == '0);
    end
  end

  // Pre-rotation register; new samples are ignored while reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_valid_q <= 1'b0;
      pre_mode_q  <= CORDIC_ROTATE;
      pre_zero_q  <= 1'b0;
      pre_x_q     <= '0;
      pre_y_q     <= '0;
      pre_z_q     <= '0;
      pre_tag_q   <= '0;
    end else if (ce) begin
      pre_valid_q <= s_valid;
      pre_mode_q  <= s_mode_e;
      pre_zero_q  <= pre_zero;
      pre_x_q     <= pre_x;
      pre_y_q     <= pre_y;
      pre_z_q     <= pre_z;
      pre_tag_q   <= s_tag;
    end
  end

  assign pipe_valid[0] = pre_valid_q;
  assign pipe_mode[0]  = pre_mode_q;
  assign pipe_zero[0]  = pre_zero_q;
  assign pipe_x[0]     = pre_x_q;
  assign pipe_y[0]     = pre_y_q;
  assign pipe_z[0]     = pre_z_q;
  assign pipe_tag[0]   = pre_tag_q;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    cordic_pipe_stage #(
      .XY_W      (XY_W),
      .Z_WIDTH   (Z_WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .IDX       (g)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .src_valid (pipe_valid[g]),
      .src_mode  (pipe_mode[g]),
      .src_zero  (pipe_zero[g]),
      .src_x     (pipe_x[g]),
      .src_y     (pipe_y[g]),
      .src_z     (pipe_z[g]),
      .src_tag   (pipe_tag[g]),
      .dst_valid (pipe_valid[g+1]),
      .dst_mode  (pipe_mode[g+1]),
      .dst_zero  (pipe_zero[g+1]),
      .dst_x     (pipe_x[g+1]),
      .dst_y     (pipe_y[g+1]),
      .dst_z     (pipe_z[g+1]),
      .dst_tag   (pipe_tag[g+1])
    );
  end

  // The last stage register is the output register. A zero vector has no
  // defined angle, so its accumulated z is replaced by 0 on the way out.
  assign m_valid = pipe_valid[STAGES];
  assign m_x     = pipe_x[STAGES];
  assign m_y     = pipe_y[STAGES];
  assign m_z     = pipe_zero[STAGES] ? '0 : pipe_z[STAGES];
  assign m_mode  = pipe_mode[STAGES];
  assign m_tag   = pipe_tag[STAGES];

endmodule

// File: tb/tb_cordic_pipe.sv
// Self-checking bench for cordic_pipe: directed vector table, random
// backpressured stream against a real-number model, full-rate latency and
// throughput, and reset with samples in flight.
module tb_cordic_pipe;

  localparam int XY_WIDTH  = 16;
  localparam int Z_WIDTH   = 16;
  localparam int STAGES    = 16;
  localparam int TAG_WIDTH = 8;
  localparam int LATENCY   = STAGES + 1;
  localparam real PI       = 3.14159265358979323846;

  typedef struct {
    bit mode;
    int x;
    int y;
    int z;
    int expX;
    int expY;
    int expZ;
    int tolXy;
    int tolZ;
  } vecRec_t;

  typedef struct {
    bit mode;
    int tag;
    int expX;
    int expY;
    int expZ;
  } expRec_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        s_valid;
  logic                        s_ready;
  logic                        s_mode;
  logic signed [XY_WIDTH-1:0]  s_x;
  logic signed [XY_WIDTH-1:0]  s_y;
  logic signed [Z_WIDTH-1:0]   s_z;
  logic [TAG_WIDTH-1:0]        s_tag;
  logic                        m_valid;
  logic                        m_ready;
  logic signed [XY_WIDTH+1:0]  m_x;
  logic signed [XY_WIDTH+1:0]  m_y;
  logic signed [Z_WIDTH-1:0]   m_z;
  logic                        m_mode;
  logic [TAG_WIDTH-1:0]        m_tag;

  int      total;
  int      bad;
  expRec_t scoreboard [$];
  vecRec_t vecs [6];

  cordic_pipe #(
    .XY_WIDTH  (XY_WIDTH),
    .Z_WIDTH   (Z_WIDTH),
    .STAGES    (STAGES),
    .TAG_WIDTH (TAG_WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_mode  (s_mode),
    .s_x     (s_x),
    .s_y     (s_y),
    .s_z     (s_z),
    .s_tag   (s_tag),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_x     (m_x),
    .m_y     (m_y),
    .m_z     (m_z),
    .m_mode  (m_mode),
    .m_tag   (m_tag)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic int roundReal(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // Accumulated CORDIC gain: product of sqrt(1 + 2^-2i) over all stages.
  function automatic real cordicGain();
    real k;
    real p;
    k = 1.0;
    p = 1.0;
    for (int i = 0; i < STAGES; i++) begin
      k = k * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    return k;
  endfunction

  // Ideal result: exact rotation / magnitude-and-angle, scaled by the gain.
  function automatic expRec_t refModel(input bit mode, input int x, input int y,
                                       input int z, input int tag);
    expRec_t r;
    real g;
    real ang;
    g      = cordicGain();
    r.mode = mode;
    r.tag  = tag & 8'hFF;
    if (!mode) begin
      ang    = real'(z) * PI / 32768.0;
      r.expX = roundReal(g * (real'(x) * $cos(ang) - real'(y) * $sin(ang)));
      r.expY = roundReal(g * (real'(x) * $sin(ang) + real'(y) * $cos(ang)));
      r.expZ = 0;
    end else begin
      r.expX = roundReal(g * $sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
      r.expY = 0;
      if (x == 0 && y == 0) r.expZ = 0;
      else r.expZ = roundReal($atan2(real'(y), real'(x)) / PI * 32768.0);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected,
                             input int tol);
    int diff;
    total++;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (+/-%0d)", name, actual, expected, tol);
    end
  endtask

  // Angle comparison modulo a full turn.
  task automatic checkAngle(input string name, input int actual, input int expected,
                            input int tol);
    int diff;
    total++;
    diff = (((actual - expected) % 65536) + 65536) % 65536;
    if (diff >= 32768) diff = diff - 65536;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (+/-%0d mod 2^16)", name, actual, expected, tol);
    end
  endtask

  task automatic applyStimulus(input bit valid, input bit mode, input int x, input int y,
                               input int z, input int tag);
    s_valid = valid;
    s_mode  = mode;
    s_x     = XY_WIDTH'(x);
    s_y     = XY_WIDTH'(y);
    s_z     = Z_WIDTH'(z);
    s_tag   = TAG_WIDTH'(tag);
  endtask

  task automatic runSingle(input vecRec_t v, input int idx);
    int lat;
    @(posedge clk); #1;
    applyStimulus(1'b1, v.mode, v.x, v.y, v.z, 100 + idx);
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput($sformatf("vec%0d accept", idx), int'(s_ready), 1, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!m_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("vec%0d latency", idx), lat, LATENCY, 0);
    if (m_valid) begin
      checkOutput($sformatf("vec%0d m_x", idx), int'(m_x), v.expX, v.tolXy);
      checkOutput($sformatf("vec%0d m_y", idx), int'(m_y), v.expY, v.tolXy);
      checkAngle($sformatf("vec%0d m_z", idx), int'(m_z), v.expZ, v.tolZ);
      checkOutput($sformatf("vec%0d m_tag", idx), int'(m_tag), 100 + idx, 0);
      checkOutput($sformatf("vec%0d m_mode", idx), int'(m_mode), int'(v.mode), 0);
    end
    @(negedge clk);
    checkOutput($sformatf("vec%0d single output", idx), int'(m_valid), 0, 0);
  endtask

  // Random tagged samples; the output side either toggles m_ready randomly
  // (with one forced 5-cycle stall) or accepts every cycle.
  task automatic runStream(input int count, input bit randomReady, input string label);
    expRec_t ex;
    int sent;
    int got;
    int cyc;
    int firstAccept;
    int firstOut;
    int lastOut;
    bit pending;
    bit curMode;
    int curX;
    int curY;
    int curZ;
    sent = 0; got = 0; cyc = 0;
    firstAccept = -1; firstOut = -1; lastOut = -1;
    pending = 1'b0;
    curMode = 1'b0; curX = 0; curY = 0; curZ = 0;
    while (got < count && cyc < 4000) begin
      @(posedge clk); #1;
      if (!pending && sent < count) begin
        curMode = 1'($urandom_range(0, 1));
        curX    = int'($urandom_range(0, 60000)) - 30000;
        curY    = int'($urandom_range(0, 60000)) - 30000;
        if (curX > -4000 && curX < 4000 && curY > -4000 && curY < 4000) curX = curX + 8000;
        curZ    = int'($urandom_range(0, 65535)) - 32768;
        pending = 1'b1;
      end
      applyStimulus(pending, curMode, curX, curY, curZ, sent);
      if (randomReady) m_ready = (cyc >= 30 && cyc < 35) ? 1'b0 : 1'($urandom_range(0, 1));
      else m_ready = 1'b1;
      @(negedge clk);
      checkOutput({label, " s_ready"}, int'(s_ready), (m_valid && !m_ready) ? 0 : 1, 0);
      if (m_valid && m_ready) begin
        if (scoreboard.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL %s unexpected output: got tag %0d, want none", label, m_tag);
        end else begin
          ex = scoreboard.pop_front();
          checkOutput({label, " m_tag"}, int'(m_tag), ex.tag, 0);
          checkOutput({label, " m_mode"}, int'(m_mode), int'(ex.mode), 0);
          checkOutput({label, " m_x"}, int'(m_x), ex.expX, 48);
          checkOutput({label, " m_y"}, int'(m_y), ex.expY, 48);
          checkAngle({label, " m_z"}, int'(m_z), ex.expZ, ex.mode ? 8 : 3);
        end
        if (firstOut < 0) firstOut = cyc;
        lastOut = cyc;
        got++;
      end
      if (s_valid && s_ready) begin
        scoreboard.push_back(refModel(curMode, curX, curY, curZ, sent));
        if (firstAccept < 0) firstAccept = cyc;
        sent++;
        pending = 1'b0;
      end
      cyc++;
    end
    s_valid = 1'b0;
    checkOutput({label, " outputs"}, got, count, 0);
    checkOutput({label, " leftover"}, scoreboard.size(), 0, 0);
    if (!randomReady) begin
      checkOutput({label, " first latency"}, firstOut - firstAccept, LATENCY, 0);
      checkOutput({label, " output span"}, lastOut - firstOut, count - 1, 0);
    end
  endtask

  // Fill the pipe, stall it with output valid, then reset for one clock.
  task automatic runResetTest();
    int lat;
    int seen;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, 5000 + i * 100, 0, 4096, 200 + i);
      m_ready = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("rst fill accept %0d", i), int'(s_ready), 1, 0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!m_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("rst pipe reached output", int'(m_valid), 1, 0);
    checkOutput("rst stalled s_ready", int'(s_ready), 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1234, 4321, 0, 77);
    m_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst m_valid next clk", int'(m_valid), 0, 0);
    checkOutput("rst m_x cleared", int'(m_x), 0, 0);
    checkOutput("rst m_tag cleared", int'(m_tag), 0, 0);
    checkOutput("rst s_ready after", int'(s_ready), 1, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    checkOutput("rst discarded samples", seen, 0, 0);
  endtask

  // Guard against a hung run.
  initial begin
    #2000000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    m_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);

    vecs[0] = '{1'b0,  10000,     0,   8192,  11645, 11645,     0, 4, 2};
    vecs[1] = '{1'b0,  10000,     0, -32768, -16468,     0,     0, 4, 2};
    vecs[2] = '{1'b0,  10000,     0,  24576, -11645, 11645,     0, 4, 2};
    vecs[3] = '{1'b1,      0, 10000,      0,  16468,     0, 16384, 4, 2};
    vecs[4] = '{1'b1, -10000,     0,      0,  16468,     0, 32768, 4, 2};
    vecs[5] = '{1'b1,      0,     0,      0,      0,     0,     0, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset m_valid", int'(m_valid), 0, 0);
    checkOutput("reset m_x", int'(m_x), 0, 0);
    checkOutput("reset m_y", int'(m_y), 0, 0);
    checkOutput("reset m_z", int'(m_z), 0, 0);
    checkOutput("reset m_tag", int'(m_tag), 0, 0);
    checkOutput("reset m_mode", int'(m_mode), 0, 0);
    checkOutput("reset s_ready", int'(s_ready), 1, 0);

    for (int i = 0; i < 6; i++) begin
      runSingle(vecs[i], i);
    end

    runStream(64, 1'b1, "random");
    runStream(40, 1'b0, "fullrate");
    runResetTest();

    $display("[TB] comparisons complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
